mem_access_stage: RTL and testbench

//   MEM stage of the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register.

---
 rtl/mem_access_if.sv | 20 ++
 rtl/mem_access_stage.sv | 151 +++++++++++++++
 tb/tb_mem_access_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata_in;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata_in
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata_in
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: runs one load/store per op over the req/ack bus, stalls the
// pipeline while the access is in flight, steers byte lanes for stores and
// extracts/extends load data into the registered mem_rdata_o.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_read_i,
    input  logic        ex_mem_write_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [1:0]  ex_size_i,
    input  logic        ex_unsigned_i,
    output logic        stall_o,
    output logic [31:0] mem_rdata_o,
    output logic        misalign_err_o,
    output logic        bus_err_o,
    mem_access_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          req_q, we_q, bus_err_q, uns_q;
    logic [31:2]   waddr_q;
    logic [1:0]    lo_q, size_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q, rdata_q;

    logic          op, misaligned;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ld_ext;

    assign op = ex_mem_read_i | ex_mem_write_i;

    // Alignment check and store lane steering from the live EX/MEM request
    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'hF;
        wdata_d    = ex_wdata_i;
        case (ex_size_i)
            2'b00: begin
                be_d    = 4'b0001 << ex_addr_i[1:0];
                wdata_d = {4{ex_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = ex_addr_i[0];
                be_d       = ex_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{ex_wdata_i[15:0]}};
            end
            default: misaligned = (ex_addr_i[1:0] != 2'b00);
        endcase
    end

    // Load lane select and extension, driven by the request latched in IDLE
    always_comb begin
        case (lo_q)
            2'd0:    byte_v = bus.mem_rdata_in[7:0];
            2'd1:    byte_v = bus.mem_rdata_in[15:8];
            2'd2:    byte_v = bus.mem_rdata_in[23:16];
            default: byte_v = bus.mem_rdata_in[31:24];
        endcase
        half_v = lo_q[1] ? bus.mem_rdata_in[31:16] : bus.mem_rdata_in[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & byte_v[7]}}, byte_v};
            2'b01:   ld_ext = {{16{~uns_q & half_v[15]}}, half_v};
            default: ld_ext = bus.mem_rdata_in;
        endcase
    end

    // Stall covers the IDLE cycle that accepts the op plus every ACCESS cycle
    always_comb begin
        stall_o        = 1'b0;
        misalign_err_o = 1'b0;
        if (!rst) begin
            stall_o        = (state_q == S_ACCESS) || (state_q == S_IDLE && op && !misaligned);
            misalign_err_o = (state_q == S_IDLE) && op && misaligned;
        end
    end

    // Access FSM: latch request, hold bus stable until ack or timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'h0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            lo_q      <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op && !misaligned) begin
                        waddr_q <= ex_addr_i[31:2];
                        lo_q    <= ex_addr_i[1:0];
                        size_q  <= ex_size_i;
                        uns_q   <= ex_unsigned_i;
                        we_q    <= ex_mem_write_i;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_ACCESS;
                    end else if (op) begin
                        rdata_q <= '0;
                    end
                end
                S_ACCESS: begin
                    // Ack wins over a timeout expiring in the same cycle
                    if (bus.mem_ack) begin
                        if (!we_q) rdata_q <= ld_ext;
                        req_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        req_q     <= 1'b0;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    bus_err_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = {waddr_q, 2'b00};
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign mem_rdata_o   = rdata_q;
    assign bus_err_o     = bus_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment,
// timeout, ack-at-expiry and reset during an access.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_read, ex_mem_write, ex_unsigned;
    logic [31:0] ex_addr, ex_wdata;
    logic [1:0]  ex_size;
    logic        stall_o, misalign_err_o, bus_err_o;
    logic [31:0] mem_rdata_o;
    int          n_pass = 0;
    int          n_total = 0;

    mem_access_if bus();

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_read_i(ex_mem_read), .ex_mem_write_i(ex_mem_write),
        .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_size_i(ex_size),
        .ex_unsigned_i(ex_unsigned),
        .stall_o(stall_o), .mem_rdata_o(mem_rdata_o),
        .misalign_err_o(misalign_err_o), .bus_err_o(bus_err_o),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Stimulus driver: presents one op, acks after `waits` non-ack req cycles
    // (waits<0 = never), and records what the bus and stage did.
    task automatic do_access(
        input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
        input logic [1:0] sz, input logic uns, input int waits, input logic [31:0] rdin,
        output int n_stall, output int n_req, output int n_unst,
        output logic saw_mis, output logic saw_err,
        output logic [31:0] o_addr, output logic [31:0] o_wdata, output logic [3:0] o_be,
        output logic o_we, output logic [31:0] o_rdata);
        bit done;
        int cyc;
        @(negedge clk);
        ex_mem_read = rd; ex_mem_write = wr; ex_addr = addr; ex_wdata = wd;
        ex_size = sz; ex_unsigned = uns; bus.mem_ack = 1'b0; bus.mem_rdata_in = rdin;
        n_stall = 0; n_req = 0; n_unst = 0; saw_mis = 0; saw_err = 0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 0; o_rdata = '0;
        done = 0; cyc = 0;
        while (!done && cyc < 40) begin
            #1;
            if (misalign_err_o) saw_mis = 1;
            if (bus.mem_req) begin
                if (n_req == 0) begin
                    o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_be = bus.mem_be; o_we = bus.mem_we;
                end else if (bus.mem_addr !== o_addr || bus.mem_wdata !== o_wdata ||
                             bus.mem_be !== o_be || bus.mem_we !== o_we) begin
                    n_unst++;
                end
                n_req++;
            end
            if (stall_o) begin
                n_stall++;
                bus.mem_ack = (waits >= 0) && bus.mem_req && (n_req == waits + 1);
                @(negedge clk);
                cyc++;
            end else begin
                done = 1;
                saw_err = bus_err_o;
                bus.mem_ack = 1'b0;
                if (cyc == 0) @(negedge clk);
            end
        end
        ex_mem_read = 0; ex_mem_write = 0;
        bus.mem_ack = 1'b0;
        #1 o_rdata = mem_rdata_o;
    endtask

    int ns, nr, nu;
    logic sm, se, owe;
    logic [31:0] oa, ow, ord;
    logic [3:0] ob;

    task automatic test_reset();
        rst = 1; ex_mem_read = 1; ex_mem_write = 0; ex_addr = 32'h40; ex_wdata = 0;
        ex_size = 2'b10; ex_unsigned = 0; bus.mem_ack = 0; bus.mem_rdata_in = 0;
        #3;
        n_total++; if (stall_o !== 1'b0) $display("FAIL rst_stall got %b want 0", stall_o); else n_pass++;
        ex_addr = 32'h41; #1;
        n_total++; if (misalign_err_o !== 1'b0) $display("FAIL rst_misalign got %b want 0", misalign_err_o); else n_pass++;
        n_total++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus_err_o} !== 7'd0)
            $display("FAIL rst_ctrl got %b want 0", {bus.mem_req, bus.mem_we, bus.mem_be, bus_err_o}); else n_pass++;
        n_total++; if ({bus.mem_addr, bus.mem_wdata, mem_rdata_o} !== 96'd0)
            $display("FAIL rst_data got %h want 0", {bus.mem_addr, bus.mem_wdata, mem_rdata_o}); else n_pass++;
        @(negedge clk); @(negedge clk);
        ex_mem_read = 0; rst = 0;
    endtask

    task automatic test_load_word();
        do_access(1, 0, 32'h40, 0, 2'b10, 0, 0, 32'hDEADBEEF, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (ns !== 2) $display("FAIL lw_stall got %0d want 2", ns); else n_pass++;
        n_total++; if (nr !== 1) $display("FAIL lw_req got %0d want 1", nr); else n_pass++;
        n_total++; if (oa !== 32'h40 || ob !== 4'hF || owe !== 1'b0)
            $display("FAIL lw_bus got addr=%h be=%h we=%b want 40 F 0", oa, ob, owe); else n_pass++;
        n_total++; if (ord !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h want deadbeef", ord); else n_pass++;
    endtask

    task automatic test_store();
        do_access(0, 1, 32'h13, 32'hA5, 2'b00, 0, 3, 32'h12345678, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (ob !== 4'b1000 || ow !== 32'hA5A5A5A5 || owe !== 1'b1 || oa !== 32'h10)
            $display("FAIL sb_bus got be=%b wd=%h we=%b a=%h want 1000 a5a5a5a5 1 10", ob, ow, owe, oa); else n_pass++;
        n_total++; if (nr !== 4 || nu !== 0) $display("FAIL sb_req got req=%0d unstable=%0d want 4 0", nr, nu); else n_pass++;
        n_total++; if (ns !== 5) $display("FAIL sb_stall got %0d want 5", ns); else n_pass++;
        n_total++; if (ord !== 32'hDEADBEEF) $display("FAIL sb_rdata_hold got %h want deadbeef", ord); else n_pass++;
        do_access(0, 1, 32'h12, 32'h1234BEEF, 2'b01, 0, 1, 0, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (ob !== 4'b1100 || ow !== 32'hBEEFBEEF)
            $display("FAIL sh_bus got be=%b wd=%h want 1100 beefbeef", ob, ow); else n_pass++;
    endtask

    task automatic test_load_ext();
        do_access(1, 0, 32'h22, 0, 2'b00, 0, 0, 32'h00800000, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (ord !== 32'hFFFFFF80) $display("FAIL lb_signed got %h want ffffff80", ord); else n_pass++;
        do_access(1, 0, 32'h22, 0, 2'b00, 1, 0, 32'h00800000, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (ord !== 32'h00000080) $display("FAIL lbu got %h want 00000080", ord); else n_pass++;
        do_access(1, 0, 32'h22, 0, 2'b01, 0, 0, 32'h80010000, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (ord !== 32'hFFFF8001) $display("FAIL lh_hi got %h want ffff8001", ord); else n_pass++;
        do_access(1, 0, 32'h20, 0, 2'b01, 1, 0, 32'h1234ABCD, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (ord !== 32'h0000ABCD) $display("FAIL lhu_lo got %h want 0000abcd", ord); else n_pass++;
        do_access(1, 0, 32'h23, 0, 2'b00, 0, 0, 32'h7F000000, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (ord !== 32'h0000007F) $display("FAIL lb_b3 got %h want 0000007f", ord); else n_pass++;
    endtask

    task automatic test_misalign();
        do_access(1, 0, 32'h31, 0, 2'b01, 0, 0, 32'hFFFFFFFF, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (sm !== 1'b1 || ns !== 0 || nr !== 0)
            $display("FAIL lh_mis got mis=%b stall=%0d req=%0d want 1 0 0", sm, ns, nr); else n_pass++;
        n_total++; if (ord !== 32'h0) $display("FAIL lh_mis_rdata got %h want 0", ord); else n_pass++;
        do_access(1, 0, 32'h42, 0, 2'b10, 0, 0, 0, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (sm !== 1'b1 || nr !== 0) $display("FAIL lw_mis got mis=%b req=%0d want 1 0", sm, nr); else n_pass++;
    endtask

    task automatic test_ack_ignored();
        do_access(1, 0, 32'h44, 0, 2'b10, 0, 0, 32'hCAFEF00D, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        @(negedge clk);
        bus.mem_ack = 1; bus.mem_rdata_in = 32'h11111111;
        @(negedge clk); #1;
        n_total++; if (mem_rdata_o !== 32'hCAFEF00D || stall_o !== 1'b0 || bus.mem_req !== 1'b0)
            $display("FAIL idle_ack got rdata=%h stall=%b req=%b want cafef00d 0 0", mem_rdata_o, stall_o, bus.mem_req); else n_pass++;
        bus.mem_ack = 0;
    endtask

    task automatic test_timeout();
        do_access(1, 0, 32'h50, 0, 2'b10, 0, -1, 0, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (nr !== 16) $display("FAIL to_req got %0d want 16", nr); else n_pass++;
        n_total++; if (ns !== 17) $display("FAIL to_stall got %0d want 17", ns); else n_pass++;
        n_total++; if (se !== 1'b1) $display("FAIL to_buserr got %b want 1", se); else n_pass++;
        n_total++; if (ord !== 32'h0) $display("FAIL to_rdata got %h want 0", ord); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (bus_err_o !== 1'b0) $display("FAIL to_buserr_clear got %b want 0", bus_err_o); else n_pass++;
    endtask

    task automatic test_ack_at_expiry();
        do_access(1, 0, 32'h80, 0, 2'b10, 0, 15, 32'h0BADF00D, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (nr !== 16 || se !== 1'b0 || ord !== 32'h0BADF00D)
            $display("FAIL ack_expiry got req=%0d err=%b rdata=%h want 16 0 0badf00d", nr, se, ord); else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        ex_mem_read = 1; ex_addr = 32'h40; ex_size = 2'b10; ex_unsigned = 0;
        @(negedge clk); #1;
        n_total++; if (bus.mem_req !== 1'b1) $display("FAIL rma_req1 got %b want 1", bus.mem_req); else n_pass++;
        @(negedge clk);
        rst = 1; #1;
        n_total++; if (bus.mem_req !== 1'b0 || stall_o !== 1'b0)
            $display("FAIL rma_abort got req=%b stall=%b want 0 0", bus.mem_req, stall_o); else n_pass++;
        ex_mem_read = 0;
        @(negedge clk);
        rst = 0; #1;
        n_total++; if (bus.mem_req !== 1'b0 || stall_o !== 1'b0)
            $display("FAIL rma_idle got req=%b stall=%b want 0 0", bus.mem_req, stall_o); else n_pass++;
        do_access(1, 0, 32'h44, 0, 2'b10, 0, 1, 32'h13579BDF, ns, nr, nu, sm, se, oa, ow, ob, owe, ord);
        n_total++; if (ns !== 3 || ord !== 32'h13579BDF || oa !== 32'h44)
            $display("FAIL rma_new got stall=%0d rdata=%h addr=%h want 3 13579bdf 44", ns, ord, oa); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store();
        test_load_ext();
        test_misalign();
        test_ack_ignored();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
